// File: rtl/boreal_biquad_cascade_if.sv
`default_nettype none
// ============================================================================
// Module   : boreal_biquad_cascade_if
// Purpose  : Sample stream bundle for the biquad cascade. It carries an input
//            handshake (valid/ready, channel, sample) and an output strobe
//            (valid, channel, filtered sample).
// Ports    : in_valid/in_ready/in_ch/x_in   - offered sample and acceptance
//            out_valid/out_ch/y_out         - single-cycle result strobe
// Modports : master - sample producer / result consumer
//            slave  - the filter block
// Revision : 1.0 - initial release
// ============================================================================
interface boreal_biquad_cascade_if #(
    parameter int DATA_W = 24,
    parameter int CH_W   = 1
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CH_W-1:0]          in_ch;
    logic signed [DATA_W-1:0] x_in;
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] y_out;

    modport master (
        output in_valid, in_ch, x_in,
        input  in_ready, out_valid, out_ch, y_out
    );

    modport slave (
        input  in_valid, in_ch, x_in,
        output in_ready, out_valid, out_ch, y_out
    );
endinterface
`default_nettype wire

// File: rtl/boreal_biquad_cascade.sv
`default_nettype none
// ============================================================================
// Module   : boreal_biquad_cascade
// Purpose  : Multi-channel cascade of NUM_SECTIONS Direct Form I biquads that
//            share one multiplier-accumulator. Each section output is rounded
//            half-up and saturated to DATA_W bits. Coefficients are shared by
//            all channels; histories are private to each channel.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            s (slave)           - sample in / result out stream
//            busy                - computation in progress
//            sat_flag / sat_clr  - sticky saturation flag and its clear
//            state_clr           - zero every history, abort in-flight sample
//            reg_addr/din/we     - coefficient write port (section*5+k)
//            reg_rdata           - combinational coefficient read-back
//            reg_err             - one-cycle pulse on a rejected write
// Revision : 1.0 - initial release
// ============================================================================
module boreal_biquad_cascade #(
    parameter int  DATA_W       = 24,
    parameter int  COEF_W       = 16,
    parameter int  COEF_FRAC    = 14,
    parameter int  NUM_SECTIONS = 4,
    parameter int  NUM_CH       = 2,
    parameter int  ACC_W        = 48,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int ADDR_W       = $clog2(5*NUM_SECTIONS)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    boreal_biquad_cascade_if.slave s,
    output logic                   busy,
    output logic                   sat_flag,
    input  wire logic              sat_clr,
    input  wire logic              state_clr,
    input  wire logic [ADDR_W-1:0] reg_addr,
    input  wire logic [COEF_W-1:0] reg_din,
    input  wire logic              reg_we,
    output logic [COEF_W-1:0]      reg_rdata,
    output logic                   reg_err
);
    localparam int NCOEF  = 5*NUM_SECTIONS;
    localparam int SEC_W  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic signed [ACC_W-1:0]  c_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  c_min = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  c_rnd = {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
    localparam logic signed [COEF_W-1:0] c_one = {{(COEF_W-COEF_FRAC-1){1'b0}}, 1'b1, {COEF_FRAC{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                   r_state;
    logic signed [COEF_W-1:0] r_coef [NCOEF];
    logic signed [DATA_W-1:0] r_x1 [NUM_CH][NUM_SECTIONS];
    logic signed [DATA_W-1:0] r_x2 [NUM_CH][NUM_SECTIONS];
    logic signed [DATA_W-1:0] r_y1 [NUM_CH][NUM_SECTIONS];
    logic signed [DATA_W-1:0] r_y2 [NUM_CH][NUM_SECTIONS];
    logic signed [DATA_W-1:0] r_x;      // input of the section being computed
    logic [CH_W-1:0]          r_ch;
    logic [SEC_W-1:0]         r_sec;
    logic [2:0]               r_k;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_y_out;
    logic [CH_W-1:0]          r_out_ch;
    logic                     r_out_valid;
    logic                     r_sat;
    logic                     r_err;

    logic [ADDR_W-1:0]        w_cidx;
    logic signed [DATA_W-1:0] w_opnd;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_shift;
    logic signed [DATA_W-1:0] w_res;
    logic                     w_clamp;
    logic                     w_last_k;
    logic                     w_last_sec;
    logic                     w_ch_ok;
    logic                     w_addr_ok;
    logic                     w_sat_evt;

    assign w_cidx     = ADDR_W'(int'(r_sec) * 5 + int'(r_k));
    assign w_last_k   = (r_k == 3'd4);
    assign w_last_sec = (r_sec == SEC_W'(NUM_SECTIONS-1));
    assign w_ch_ok    = (int'(s.in_ch) < NUM_CH);
    assign w_addr_ok  = (int'(reg_addr) < NCOEF);

    // One product per MAC cycle; feedback terms are subtracted rather than
    // negating the coefficient, so a1/a2 = most-negative code stays exact.
    always_comb begin
        w_opnd = r_x;
        case (r_k)
            3'd1:    w_opnd = r_x1[r_ch][r_sec];
            3'd2:    w_opnd = r_x2[r_ch][r_sec];
            3'd3:    w_opnd = r_y1[r_ch][r_sec];
            3'd4:    w_opnd = r_y2[r_ch][r_sec];
            default: w_opnd = r_x;
        endcase
        w_coef     = r_coef[w_cidx];
        w_prod     = w_opnd * w_coef;
        w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
        w_sum      = (r_k >= 3'd3) ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
        w_shift    = (w_sum + c_rnd) >>> COEF_FRAC;
        w_clamp    = 1'b1;
        if (w_shift > c_max) begin
            w_res = c_max[DATA_W-1:0];
        end else if (w_shift < c_min) begin
            w_res = c_min[DATA_W-1:0];
        end else begin
            w_res   = w_shift[DATA_W-1:0];
            w_clamp = 1'b0;
        end
    end

    assign w_sat_evt = (r_state == S_MAC) && w_last_k && w_clamp && !state_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_ch        <= '0;
            r_sec       <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_y_out     <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < NCOEF; i++) begin
                r_coef[i] <= (i % 5 == 0) ? c_one : '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                for (int j = 0; j < NUM_SECTIONS; j++) begin
                    r_x1[c][j] <= '0;
                    r_x2[c][j] <= '0;
                    r_y1[c][j] <= '0;
                    r_y2[c][j] <= '0;
                end
            end
        end else begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;

            // Writes land on this edge, so a sample accepted on the same edge
            // already sees the new coefficient in its first MAC cycle.
            if (reg_we) begin
                if (r_state == S_IDLE && w_addr_ok) begin
                    r_coef[reg_addr] <= reg_din;
                end else begin
                    r_err <= 1'b1;
                end
            end

            if (w_sat_evt) begin
                r_sat <= 1'b1;
            end else if (sat_clr) begin
                r_sat <= 1'b0;
            end

            if (state_clr) begin
                r_state <= S_IDLE;
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int j = 0; j < NUM_SECTIONS; j++) begin
                        r_x1[c][j] <= '0;
                        r_x2[c][j] <= '0;
                        r_y1[c][j] <= '0;
                        r_y2[c][j] <= '0;
                    end
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Out-of-range channels are consumed without effect.
                        if (s.in_valid && w_ch_ok) begin
                            r_x     <= s.x_in;
                            r_ch    <= s.in_ch;
                            r_sec   <= '0;
                            r_k     <= '0;
                            r_acc   <= '0;
                            r_state <= S_MAC;
                        end
                    end
                    S_MAC: begin
                        if (!w_last_k) begin
                            r_acc <= w_sum;
                            r_k   <= r_k + 3'd1;
                        end else begin
                            r_x2[r_ch][r_sec] <= r_x1[r_ch][r_sec];
                            r_x1[r_ch][r_sec] <= r_x;
                            r_y2[r_ch][r_sec] <= r_y1[r_ch][r_sec];
                            r_y1[r_ch][r_sec] <= w_res;
                            r_x               <= w_res;
                            r_acc             <= '0;
                            r_k               <= '0;
                            if (w_last_sec) begin
                                r_y_out     <= w_res;
                                r_out_ch    <= r_ch;
                                r_out_valid <= 1'b1;
                                r_state     <= S_WRITE;
                            end else begin
                                r_sec <= r_sec + 1'b1;
                            end
                        end
                    end
                    S_WRITE: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign s.in_ready  = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign s.out_valid = r_out_valid;
    assign s.out_ch    = r_out_ch;
    assign s.y_out     = r_y_out;
    assign sat_flag    = r_sat;
    assign reg_err     = r_err;
    assign reg_rdata   = w_addr_ok ? r_coef[reg_addr] : '0;
endmodule
`default_nettype wire

// File: tb/tb_boreal_biquad_cascade.sv
`default_nettype none
// ============================================================================
// Module   : tb_boreal_biquad_cascade
// Purpose  : Self-checking bench for boreal_biquad_cascade. Directed scenarios
//            plus randomized samples and coefficients checked against an
//            arithmetic reference model of the cascade.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boreal_biquad_cascade;
    localparam int DATA_W = 24;
    localparam int COEF_W = 16;
    localparam int COEF_FRAC = 14;
    localparam int NUM_SECTIONS = 4;
    localparam int NUM_CH = 2;
    localparam int ACC_W = 48;
    localparam int CH_W = 1;
    localparam int ADDR_W = 5;
    localparam int NCOEF = 5*NUM_SECTIONS;
    localparam int LAT = 5*NUM_SECTIONS + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, sat_flag, sat_clr, state_clr, reg_we, reg_err;
    logic [ADDR_W-1:0] reg_addr;
    logic [COEF_W-1:0] reg_din, reg_rdata;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    boreal_biquad_cascade_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

    boreal_biquad_cascade #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC),
        .NUM_SECTIONS(NUM_SECTIONS), .NUM_CH(NUM_CH), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s(bus), .busy(busy), .sat_flag(sat_flag),
        .sat_clr(sat_clr), .state_clr(state_clr), .reg_addr(reg_addr),
        .reg_din(reg_din), .reg_we(reg_we), .reg_rdata(reg_rdata), .reg_err(reg_err)
    );

    // ---------------- reference model ----------------
    longint m_coef [NCOEF];
    longint m_x1 [NUM_CH][NUM_SECTIONS];
    longint m_x2 [NUM_CH][NUM_SECTIONS];
    longint m_y1 [NUM_CH][NUM_SECTIONS];
    longint m_y2 [NUM_CH][NUM_SECTIONS];

    function automatic void model_reset_coef();
        for (int i = 0; i < NCOEF; i++) m_coef[i] = (i % 5 == 0) ? (64'sd1 << COEF_FRAC) : 0;
    endfunction

    function automatic void model_clear_hist();
        for (int c = 0; c < NUM_CH; c++)
            for (int j = 0; j < NUM_SECTIONS; j++) begin
                m_x1[c][j] = 0; m_x2[c][j] = 0; m_y1[c][j] = 0; m_y2[c][j] = 0;
            end
    endfunction

    // y = round_half_up((b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) / 2^FRAC), clamped
    function automatic longint model_run(int ch, longint x);
        longint v = x;
        longint acc, y;
        longint hi = (64'sd1 << (DATA_W-1)) - 1;
        longint lo = -(64'sd1 << (DATA_W-1));
        for (int j = 0; j < NUM_SECTIONS; j++) begin
            acc = m_coef[j*5]*v + m_coef[j*5+1]*m_x1[ch][j] + m_coef[j*5+2]*m_x2[ch][j]
                - m_coef[j*5+3]*m_y1[ch][j] - m_coef[j*5+4]*m_y2[ch][j];
            y = (acc + (64'sd1 << (COEF_FRAC-1))) >>> COEF_FRAC;
            if (y > hi) y = hi;
            if (y < lo) y = lo;
            m_x2[ch][j] = m_x1[ch][j]; m_x1[ch][j] = v;
            m_y2[ch][j] = m_y1[ch][j]; m_y1[ch][j] = y;
            v = y;
        end
        return v;
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic write_coef(input int addr, input int data, input bit exp_err);
        @(negedge clk);
        reg_we = 1'b1; reg_addr = ADDR_W'(addr); reg_din = COEF_W'(data);
        @(negedge clk);
        reg_we = 1'b0;
        n_checks++;
        if (reg_err !== exp_err) begin
            n_fail++;
            $display("FAIL write_coef addr=%0d reg_err: got %b want %b", addr, reg_err, exp_err);
        end
        if (!exp_err) m_coef[addr] = longint'(data);
    endtask

    task automatic pulse_state_clr();
        @(negedge clk); state_clr = 1'b1;
        @(negedge clk); state_clr = 1'b0;
        model_clear_hist();
    endtask

    // Offers one sample, waits (bounded) for the result. clean=0 if in_ready
    // misbehaved or out_valid was not a single-cycle pulse.
    task automatic send(input int ch, input logic signed [DATA_W-1:0] x,
                        output logic signed [DATA_W-1:0] y, output logic [CH_W-1:0] och,
                        output int lat, output bit clean);
        clean = 1'b1; lat = -1; y = 'x; och = 'x;
        @(negedge clk);
        if (bus.in_ready !== 1'b1) clean = 1'b0;
        bus.in_valid = 1'b1; bus.in_ch = ch[CH_W-1:0]; bus.x_in = x;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                lat = n; y = bus.y_out; och = bus.out_ch;
                break;
            end
            if (bus.in_ready !== 1'b0) clean = 1'b0;
        end
        if (lat > 0) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) clean = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        reg_addr = '0;
        #12;
        n_checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.y_out !== '0 ||
            bus.out_ch !== '0 || sat_flag !== 1'b0 || reg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b busy=%b ov=%b y=%0d ch=%b sat=%b err=%b",
                     bus.in_ready, busy, bus.out_valid, bus.y_out, bus.out_ch, sat_flag, reg_err);
        end
        n_checks++;
        if (reg_rdata !== 16'd16384) begin
            n_fail++; $display("FAIL reset_b0: got %0d want 16384", reg_rdata);
        end
        reg_addr = 5'd1; #1;
        n_checks++;
        if (reg_rdata !== 16'd0) begin
            n_fail++; $display("FAIL reset_b1: got %0d want 0", reg_rdata);
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset_coef(); model_clear_hist();
    endtask

    task automatic test_identity();
        logic signed [DATA_W-1:0] y; logic [CH_W-1:0] och; int lat; bit clean;
        send(0, 24'sd1000, y, och, lat, clean);
        n_checks++;
        if (y !== 24'sd1000 || och !== 1'b0 || lat != LAT || !clean || sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL identity: y=%0d ch=%b lat=%0d clean=%b sat=%b, want y=1000 ch=0 lat=%0d clean=1 sat=0",
                     y, och, lat, clean, sat_flag, LAT);
        end
    endtask

    task automatic test_reg_errors();
        int lat = -1;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_ch = 1'b0; bus.x_in = 24'sd5;
        @(negedge clk); bus.in_valid = 1'b0;                       // n=1
        @(negedge clk); reg_we = 1'b1; reg_addr = 5'd2; reg_din = 16'd77;  // n=2
        @(negedge clk); reg_we = 1'b0;                             // n=3
        n_checks++;
        if (reg_err !== 1'b1) begin n_fail++; $display("FAIL busy_write_err: got %b want 1", reg_err); end
        @(negedge clk);                                            // n=4
        n_checks++;
        if (reg_err !== 1'b0) begin n_fail++; $display("FAIL err_single_pulse: got %b want 0", reg_err); end
        n_checks++;
        if (reg_rdata !== 16'd0) begin n_fail++; $display("FAIL busy_write_ignored: got %0d want 0", reg_rdata); end
        for (int n = 5; n <= 40; n++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin lat = n; break; end
        end
        n_checks++;
        if (bus.y_out !== 24'sd5 || lat != LAT) begin
            n_fail++; $display("FAIL busy_sample: y=%0d lat=%0d want y=5 lat=%0d", bus.y_out, lat, LAT);
        end
        write_coef(20, 16'h1111, 1'b1);
        #1;
        n_checks++;
        if (reg_rdata !== 16'd0) begin n_fail++; $display("FAIL oob_read: got %h want 0", reg_rdata); end
        write_coef(7, 16'h1234, 1'b0);
        #1;
        n_checks++;
        if (reg_rdata !== 16'h1234) begin n_fail++; $display("FAIL readback: got %h want 1234", reg_rdata); end
        write_coef(7, 0, 1'b0);
    endtask

    task automatic test_gain_rounding();
        logic signed [DATA_W-1:0] y; logic [CH_W-1:0] och; int lat; bit clean;
        write_coef(0, 8192, 1'b0);
        send(0, 24'sd3, y, och, lat, clean);
        n_checks++;
        if (y !== 24'sd2 || lat != LAT || !clean) begin
            n_fail++; $display("FAIL gain_pos: y=%0d lat=%0d want y=2 lat=%0d", y, lat, LAT);
        end
        send(0, -24'sd3, y, och, lat, clean);
        n_checks++;
        if (y !== -24'sd1 || lat != LAT || !clean) begin
            n_fail++; $display("FAIL gain_neg: y=%0d lat=%0d want y=-1 lat=%0d", y, lat, LAT);
        end
    endtask

    task automatic test_recursion_channels();
        int chs [7] = '{0, 1, 0, 1, 0, 1, 0};
        int xs  [7] = '{16384, 0, 0, 0, 0, 0, 0};
        int ex  [7] = '{16384, 0, 8192, 0, 4096, 0, 2048};
        logic signed [DATA_W-1:0] y; logic [CH_W-1:0] och; int lat; bit clean;
        write_coef(0, 16384, 1'b0);
        write_coef(3, -8192, 1'b0);
        pulse_state_clr();
        for (int i = 0; i < 7; i++) begin
            send(chs[i], DATA_W'(xs[i]), y, och, lat, clean);
            n_checks++;
            if (y !== DATA_W'(ex[i]) || och !== chs[i][0] || lat != LAT || !clean) begin
                n_fail++;
                $display("FAIL recursion[%0d]: y=%0d ch=%b lat=%0d want y=%0d ch=%0d", i, y, och, lat, ex[i], chs[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [DATA_W-1:0] y; logic [CH_W-1:0] och; int lat; bit clean;
        write_coef(3, 0, 1'b0);
        pulse_state_clr();
        for (int j = 0; j < NUM_SECTIONS; j++) write_coef(j*5, 32767, 1'b0);
        send(0, 24'sh400000, y, och, lat, clean);
        n_checks++;
        if (y !== 24'sh7FFFFF || sat_flag !== 1'b1) begin
            n_fail++; $display("FAIL sat_pos: y=%h sat=%b want y=7fffff sat=1", y, sat_flag);
        end
        send(0, -24'sh400000, y, och, lat, clean);
        n_checks++;
        if (y !== 24'sh800000) begin n_fail++; $display("FAIL sat_neg: y=%h want 800000", y); end
        @(negedge clk); sat_clr = 1'b1;
        @(negedge clk); sat_clr = 1'b0;
        n_checks++;
        if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clr: got %b want 0", sat_flag); end
        // sat_clr held while the last section clamps: setting must win.
        @(negedge clk);
        sat_clr = 1'b1; bus.in_valid = 1'b1; bus.in_ch = 1'b0; bus.x_in = 24'sh400000;
        @(negedge clk); bus.in_valid = 1'b0;
        repeat (LAT-1) @(negedge clk);
        sat_clr = 1'b0;
        n_checks++;
        if (sat_flag !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL sat_set_wins: sat=%b ov=%b want sat=1 ov=1", sat_flag, bus.out_valid);
        end
    endtask

    task automatic test_abort();
        logic signed [DATA_W-1:0] y; logic [CH_W-1:0] och; int lat; bit clean;
        bit seen = 1'b0;
        for (int j = 0; j < NUM_SECTIONS; j++) write_coef(j*5, 16384, 1'b0);
        write_coef(3, -8192, 1'b0);
        pulse_state_clr();
        send(0, 24'sd16384, y, och, lat, clean);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_ch = 1'b0; bus.x_in = 24'sd0;
        @(negedge clk); bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        state_clr = 1'b1;
        @(negedge clk); state_clr = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: rdy=%b busy=%b want rdy=1 busy=0", bus.in_ready, busy);
        end
        for (int n = 0; n < 30; n++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL abort_no_output: got out_valid=1 want none"); end
        model_clear_hist();
        send(0, 24'sd16384, y, och, lat, clean);
        n_checks++;
        if (y !== 24'sd16384 || lat != LAT) begin
            n_fail++; $display("FAIL abort_history: y=%0d lat=%0d want y=16384 lat=%0d", y, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic signed [DATA_W-1:0] y, x, exp_y; logic [CH_W-1:0] och; int lat; bit clean;
        int ch, v;
        pulse_state_clr();
        for (int a = 0; a < NCOEF; a++) begin
            if (a % 5 < 3) v = int'($urandom_range(0, 32768)) - 16384;
            else           v = int'($urandom_range(0, 8000)) - 4000;
            write_coef(a, v, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            ch = int'($urandom_range(0, NUM_CH-1));
            x = DATA_W'($urandom);
            exp_y = DATA_W'(model_run(ch, longint'(x)));
            send(ch, x, y, och, lat, clean);
            n_checks++;
            if (y !== exp_y || och !== ch[0] || lat != LAT || !clean) begin
                n_fail++;
                $display("FAIL random[%0d]: ch=%0d x=%0d y=%0d och=%b lat=%0d want y=%0d", i, ch, x, y, och, lat, exp_y);
            end
        end
    endtask

    task automatic test_async_reset();
        logic signed [DATA_W-1:0] y; logic [CH_W-1:0] och; int lat; bit clean;
        reg_addr = '0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_ch = 1'b1; bus.x_in = 24'sd1234;
        @(negedge clk); bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.y_out !== '0 ||
            bus.out_ch !== '0 || sat_flag !== 1'b0 || reg_rdata !== 16'd16384) begin
            n_fail++;
            $display("FAIL async_reset: rdy=%b busy=%b ov=%b y=%0d ch=%b sat=%b b0=%0d",
                     bus.in_ready, busy, bus.out_valid, bus.y_out, bus.out_ch, sat_flag, reg_rdata);
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset_coef(); model_clear_hist();
        send(1, 24'sd777, y, och, lat, clean);
        n_checks++;
        if (y !== 24'sd777 || och !== 1'b1 || lat != LAT) begin
            n_fail++; $display("FAIL post_reset_identity: y=%0d ch=%b lat=%0d want 777", y, och, lat);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_ch = '0; bus.x_in = '0;
        sat_clr = 1'b0; state_clr = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_din = '0;
        test_reset();
        test_identity();
        test_reg_errors();
        test_gain_rounding();
        test_recursion_channels();
        test_saturation();
        test_abort();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/boreal_biquad_cascade.md
Name: boreal_biquad_cascade

Overview:
Multi-channel cascade of NUM_SECTIONS second-order IIR sections (Direct Form I) sharing one time-multiplexed multiplier-accumulator. It replaces single-section, single-channel biquads in the ECG front-end filter chain, for example as a baseline-wander high-pass cascaded with a mains notch. Coefficients use the Q(COEF_W-COEF_FRAC).COEF_FRAC format, so |a1| up to 2.0 is representable. Rounding and saturation are applied at every section output.

Parameters:
DATA_W, 24, sample width (signed)
COEF_W, 16, coefficient width (signed)
COEF_FRAC, 14, coefficient fractional bits (1.0 = 1<<COEF_FRAC)
NUM_SECTIONS, 4, cascaded biquad sections
NUM_CH, 2, independent channels with private history and shared coefficients
ACC_W, 48, accumulator width (must satisfy ACC_W >= DATA_W+COEF_W+3)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample offered
in_ready  out  1  block idle and able to accept a sample
in_ch  in  max(1,$clog2(NUM_CH))  channel of the offered sample
x_in  in  DATA_W  signed input sample
out_valid  out  1  single-cycle result strobe
out_ch  out  max(1,$clog2(NUM_CH))  channel of the result
y_out  out  DATA_W  signed filtered sample
busy  out  1  computation in progress
sat_flag  out  1  sticky flag: some section output saturated
sat_clr  in  1  clears sat_flag
state_clr  in  1  clears all channel history
reg_addr  in  $clog2(5*NUM_SECTIONS)  coefficient index = section*5+k, where k is 0:b0, 1:b1, 2:b2, 3:a1, 4:a2
reg_din  in  COEF_W  coefficient write data
reg_we  in  1  coefficient write strobe
reg_rdata  out  COEF_W  combinational read-back of the addressed coefficient (0 if out of range)
reg_err  out  1  single-cycle pulse: write rejected

Behaviour:
- Reset (rst_n low, asynchronous):
  - All b0 = 1<<COEF_FRAC; all other coefficients = 0, so the cascade is identity.
  - All histories = 0.
  - y_out = 0, out_ch = 0, out_valid = 0, busy = 0, in_ready = 1, sat_flag = 0, reg_err = 0.
  - FSM goes to IDLE.
- FSM states: IDLE, MAC, WRITE.
  - IDLE: in_ready = 1. On in_valid, latch x_in and in_ch, set section = 0, k = 0, clear the accumulator, and go to MAC.
  - MAC: one product per cycle in the order b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2, all for the current channel and section. After k = 4, the section result is computed combinationally from the final sum as follows:
    - Add the rounding constant 1<<(COEF_FRAC-1), then shift arithmetically right by COEF_FRAC (round-half-up).
    - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp sets sat_flag.
    - That section's history updates: x2<=x1, x1<=x, y2<=y1, y1<=result.
    - The result becomes the input to the next section.
    - After the last section, go to WRITE.
  - WRITE: y_out <= final result, out_ch <= channel, out_valid = 1 for exactly one cycle, then return to IDLE.
- Latency: a sample accepted in cycle T (in_valid && in_ready) produces out_valid in cycle T + 5*NUM_SECTIONS + 1 (21 cycles at defaults).
- Throughput: one sample per 5*NUM_SECTIONS+2 cycles.
- in_ready = 0 and busy = 1 in MAC and WRITE.
- y_out holds its value until the next WRITE.
- Histories are fully independent per channel. Processing a sample on channel c never changes the state of any other channel.
- in_ch >= NUM_CH: the sample is accepted and dropped. No output, no state change, and the block stays in IDLE.
- Coefficient writes:
  - Take effect on the clock edge, only while IDLE.
  - reg_we while busy, or to an out-of-range address, is ignored and pulses reg_err for one cycle.
  - reg_we and in_valid in the same IDLE cycle: the write applies first, and the accepted sample uses the new coefficient.
- state_clr (synchronous, highest priority after reset): zeroes all histories of all channels and aborts any in-flight sample. No out_valid is produced and the FSM returns to IDLE next cycle. Coefficients, y_out and sat_flag are unchanged.
- sat_clr: clears sat_flag next cycle. If a saturation occurs in the same cycle as sat_clr, sat_flag = 1 (set wins).
- Arithmetic: products are DATA_W+COEF_W bits, sign-extended to ACC_W. The accumulator itself never wraps.

Test Plan:
- Identity: after reset, x_in=1000 on ch0 -> y_out=1000 with out_valid exactly 21 cycles after acceptance; in_ready low throughout; sat_flag=0.
- Gain and rounding: write addr0 (sec0 b0)=8192 (0.5); x_in=3 -> y_out=2 (1.5 rounds half-up); x_in=-3 -> y_out=-1.
- Recursion and channel isolation: write addr3 (sec0 a1)=-8192 (y=x+0.5*y1); ch0 impulse 16384 then zeros -> outputs 16384, 8192, 4096, 2048; interleaved ch1 zeros -> ch1 outputs stay 0.
- Saturation: write b0=32767 in all 4 sections; x_in=0x400000 -> y_out=0x7FFFFF and sat_flag=1; x_in=-0x400000 -> y_out=-0x800000; sat_clr -> sat_flag=0.
- Rejected write and read-back: reg_we to addr2 while busy -> reg_err pulse, reg_rdata at addr2 still 0; reg_we to addr20 -> reg_err; valid write while IDLE is read back exactly.
- Abort and reset: assert state_clr 10 cycles into a sample -> no out_valid, histories zero, next impulse reproduces the first-sample response; drop rst_n mid-MAC -> all outputs at reset values immediately, coefficients restored to identity.
